// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - LSU state encoding, funct3 width codes and access helpers
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EXT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only take signed-width codes; halves need even and words
    // need 4-byte-aligned addresses.
    function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !a[0];
            F3_HU:   ok = !is_store && !a[0];
            F3_W:    ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem.sv
// rtl/dmem.sv - single-port synchronous byte-enabled data RAM, 1-cycle read
module dmem #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit with alignment checks over a local data RAM
module lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        fault
);

    state_t state, state_n;

    logic [DEPTH_LOG2+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            f3_q;
    logic                  store_q;

    logic        req_valid;
    logic        req_ok;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;
    logic [31:0] load_ext;

    // High address bits alias onto the RAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

    assign req_valid = start && (mem_read ^ mem_write);
    assign req_ok    = access_ok(mem_write, funct3, addr[1:0]);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req_valid) state_n = req_ok ? ACC : DONE;
            ACC:  state_n = store_q ? DONE : EXT;
            EXT:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            addr_q  <= addr[DEPTH_LOG2+1:0];
            wdata_q <= wdata;
            f3_q    <= funct3;
            store_q <= mem_write;
        end
    end

    // Write enable is combinational on state, so an async reset in ACC
    // drops it before the commit edge.
    assign ram_we = (state == ACC) && store_q;
    assign ram_be = byte_en(f3_q, addr_q[1:0]);

    always_comb begin
        case (f3_q[1:0])
            2'b00:   ram_wdata = {4{wdata_q[7:0]}};
            2'b01:   ram_wdata = {2{wdata_q[15:0]}};
            default: ram_wdata = wdata_q;
        endcase
    end

    dmem #(.DEPTH_LOG2(DEPTH_LOG2)) u_dmem (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .idx   (addr_q[DEPTH_LOG2+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = ram_q[8*addr_q[1:0] +: 8];
        h = addr_q[1] ? ram_q[31:16] : ram_q[15:0];
        case (f3_q)
            F3_B:    load_ext = {{24{b[7]}}, b};
            F3_BU:   load_ext = {24'h0, b};
            F3_H:    load_ext = {{16{h[15]}}, h};
            F3_HU:   load_ext = {16'h0, h};
            default: load_ext = ram_q;
        endcase
    end

    // Only an IDLE->DONE jump can be a fault; every other completion clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            fault <= 1'b0;
            rdata <= '0;
        end else begin
            done <= (state_n == DONE);
            if (state_n == DONE) begin
                fault <= (state == IDLE);
            end
            if (state == EXT) begin
                rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed-vector self-checking bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu #(.DEPTH_LOG2(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one request, then count cycles from the sampling edge to done.
    task automatic op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic exp_fault, input logic [31:0] exp_rdata);
        int lat;
        @(negedge clk);
        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 99;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_fault"}, {31'h0, fault}, {31'h0, exp_fault});
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;

        op("sw_10",   1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        op("lw_10",   1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF);
        op("sb_13",   1'b0, 1'b1, 3'b000, 32'h13, 32'h80, 2, 1'b0, 32'hDEADBEEF);
        op("lb_13",   1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 3, 1'b0, 32'hFFFFFF80);
        op("lbu_13",  1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 3, 1'b0, 32'h00000080);
        op("lw_10b",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'h80ADBEEF);
        op("lh_12",   1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 3, 1'b0, 32'hFFFF80AD);
        op("lhu_12",  1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 3, 1'b0, 32'h000080AD);
        op("lh_11",   1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 1, 1'b1, 32'h000080AD);
        op("sw_12",   1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 1, 1'b1, 32'h000080AD);
        op("lw_10c",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0, 32'h80ADBEEF);
        op("sw_100",  1'b0, 1'b1, 3'b010, 32'h100, 32'h12345678, 2, 1'b0, 32'h80ADBEEF);
        op("lw_000",  1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 3, 1'b0, 32'h12345678);
        op("sh_02",   1'b0, 1'b1, 3'b001, 32'h2, 32'h0000CAFE, 2, 1'b0, 32'h12345678);
        op("lw_000b", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 3, 1'b0, 32'hCAFE5678);
        op("lh_02",   1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 3, 1'b0, 32'hFFFFCAFE);
        op("sw_20",   1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 2, 1'b0, 32'hFFFFCAFE);

        // Start with both or neither qualifier must be ignored.
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20;
        @(negedge clk);
        check("both_busy", {31'h0, busy}, 32'h0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("neither_busy", {31'h0, busy}, 32'h0);
        start = 1'b0;

        // Start held high while busy must not queue a second access.
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b0; mem_read = 1'b0;
            end
            if (done) dones++;
        end
        check("busy_single_done", 32'(dones), 32'd1);
        check("busy_rdata", rdata, 32'h80ADBEEF);

        // Reset during the ACC cycle of a store aborts the write.
        @(negedge clk);
        start = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; mem_write = 1'b0;
        check("acc_busy_pre", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        check("arst_fault", {31'h0, fault}, 32'h0);
        check("arst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op("lw_20",   1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 3, 1'b0, 32'h11223344);

        op("ld_f011", 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 1, 1'b1, 32'h11223344);
        op("st_f100", 1'b0, 1'b1, 3'b100, 32'h20, 32'h0, 1, 1'b1, 32'h11223344);
        op("lw_20b",  1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 3, 1'b0, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of data-memory depth in 32-bit words (64 words).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request strobe, sampled only in IDLE.
REQ-005 SHALL have port mem_read, input, 1, load request qualifier.
REQ-006 SHALL have port mem_write, input, 1, store request qualifier.
REQ-007 SHALL have port funct3, input, 3, RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port addr, input, 32, byte address (ALU result).
REQ-009 SHALL have port wdata, input, 32, store data (rs2 value).
REQ-010 SHALL have port rdata, output, 32, extended load result, registered.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse, registered.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port fault, output, 1, misaligned or illegal access flag, valid while done=1.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, EXT, DONE.
REQ-015 IDLE: start=1 with exactly one of mem_read/mem_write SHALL capture addr, wdata, funct3 and go to ACC; otherwise remain IDLE.
REQ-016 start=1 with both or neither of mem_read/mem_write SHALL be ignored.
REQ-017 start outside IDLE SHALL be ignored; no queuing.
REQ-018 Alignment rule: W requires addr[1:0]=00, H/HU requires addr[0]=0, B/BU any address.
REQ-019 Stores SHALL accept funct3 000/001/010 only; loads SHALL accept 000/001/010/100/101 only.
REQ-020 Misaligned or illegal request SHALL go IDLE->DONE directly, set fault=1, perform no memory write, leave rdata unchanged.
REQ-021 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing wrap).
REQ-022 Store: in ACC the RAM write with byte enables from addr[1:0] and width SHALL commit at the ACC->DONE edge; wdata lane-replicated (byte to all 4 lanes, half to both halves).
REQ-023 Store latency: done high in the 2nd cycle after the start-sampling edge.
REQ-024 Load: ACC issues the synchronous RAM read; EXT SHALL select byte/half by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU), and register into rdata at the EXT->DONE edge.
REQ-025 Load latency: done high in the 3rd cycle after the start-sampling edge.
REQ-026 DONE SHALL last exactly one cycle, then return to IDLE; a new start is accepted only in the following IDLE cycle.
REQ-027 rdata SHALL hold its value until the next successful load completes.
REQ-028 fault SHALL be cleared on every non-faulting completion.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, rdata=0, done=0, fault=0, busy=0.
REQ-030 Reset asserted while in ACC of a store SHALL abort the write (memory unchanged).
REQ-031 RAM contents SHALL NOT be reset.

Structure
REQ-032 Package lsu_pkg SHALL hold the FSM state encoding and funct3 width constants.
REQ-033 Sub-module dmem SHALL implement a single-port synchronous RAM, 2**DEPTH_LOG2 x 32, 4 byte-enables, 1-cycle read latency.

Verification
REQ-034 SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, done 3 cycles after start, fault=0.
REQ-035 SB wdata=0x00000080 @0x13; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-036 LH @0x11 -> done 1 cycle after start, fault=1, rdata unchanged; SW @0x12 -> fault=1, LW @0x10 still 0x80ADBEEF.
REQ-037 DEPTH_LOG2=6: SW 0x12345678 @0x100, LW @0x000 -> 0x12345678 (wrap).
REQ-038 start pulsed while busy -> ignored, single done; rst_n low during ACC of SW 0xFFFFFFFF @0x20 -> outputs 0, LW @0x20 returns prior contents.
REQ-039 funct3=011 load and funct3=100 store -> fault=1, no memory change.
